// File: rtl/gram_scheduler_if.sv
// Bus bundle between the Gram scheduler, its requester and the shared InnerProduct datapath.
// The master modport is the scheduler's view; slave is the requester/datapath side.
interface gram_scheduler_if #(
    parameter int unsigned M     = 3,
    parameter int unsigned N     = 3,
    parameter int unsigned NBITS = 32
);
    logic                        go;
    logic [NBITS*N*M-1:0]        colmat;
    logic [NBITS*N-1:0]          ip_vector1;
    logic [NBITS*N-1:0]          ip_vector2;
    logic [31:0]                 ip_maximumPos;
    logic [31:0]                 ip_resetValue;
    logic                        ip_addSubs;
    logic                        ip_start;
    logic                        ip_endflag;
    logic signed [NBITS-1:0]     ip_result;
    logic                        wr_en;
    logic [7:0]                  wr_row;
    logic [7:0]                  wr_col;
    logic [NBITS-1:0]            wr_data;
    logic                        busy;
    logic                        done;
    logic                        error;

    modport master (
        input  go, colmat, ip_endflag, ip_result,
        output ip_vector1, ip_vector2, ip_maximumPos, ip_resetValue, ip_addSubs,
               ip_start, wr_en, wr_row, wr_col, wr_data, busy, done, error
    );

    modport slave (
        output go, colmat, ip_endflag, ip_result,
        input  ip_vector1, ip_vector2, ip_maximumPos, ip_resetValue, ip_addSubs,
               ip_start, wr_en, wr_row, wr_col, wr_data, busy, done, error
    );
endinterface

// File: rtl/gram_scheduler.sv
// Drives one shared InnerProduct datapath over the upper triangle of A^T*A and
// writes each result to G[i][j] and its mirror G[j][i] through one write port.
module gram_scheduler #(
    parameter int unsigned M       = 3,
    parameter int unsigned N       = 3,
    parameter int unsigned NBITS   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    gram_scheduler_if.master bus
);
    localparam int unsigned CW = NBITS * N;
    localparam int unsigned MW = CW * M;

    typedef enum logic [3:0] {
        S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_WRITE, S_MIRROR, S_NEXT, S_DONE, S_ABORT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [MW-1:0]      r_colmat;
    logic [7:0]         r_i;
    logic [7:0]         r_j;
    logic [31:0]        r_timer;
    logic               r_ip_start;
    logic               r_wr_en;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [7:0]         r_wr_row;
    logic [7:0]         r_wr_col;
    logic [NBITS-1:0]   r_wr_data;
    logic [CW-1:0]      w_vec1;
    logic [CW-1:0]      w_vec2;
    logic               w_last_i;
    logic               w_last_j;
    logic               w_timeout;

    assign w_last_i  = (r_i == 8'(M - 1));
    assign w_last_j  = (r_j == 8'(M - 1));
    assign w_timeout = ((r_timer + 32'd1) == 32'(TIMEOUT));

    // Column select from the latched matrix; column 0 occupies the MSBs.
    always_comb begin
        w_vec1 = '0;
        w_vec2 = '0;
        for (int k = 0; k < int'(M); k++) begin
            w_vec1 = (r_i == 8'(k)) ? r_colmat[CW*(M-k)-1 -: CW] : w_vec1;
            w_vec2 = (r_j == 8'(k)) ? r_colmat[CW*(M-k)-1 -: CW] : w_vec2;
        end
    end

    // Next-state logic of the job sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.go) w_next = S_ISSUE; else w_next = S_IDLE;
            S_ISSUE:  w_next = S_ARM;
            S_ARM:    w_next = S_WAIT;
            S_WAIT: begin
                if (bus.ip_endflag)  w_next = S_WRITE;
                else if (w_timeout)  w_next = S_ABORT;
                else                 w_next = S_WAIT;
            end
            S_WRITE:  if (r_i != r_j) w_next = S_MIRROR; else w_next = S_NEXT;
            S_MIRROR: w_next = S_NEXT;
            S_NEXT:   if (w_last_i && w_last_j) w_next = S_DONE; else w_next = S_ISSUE;
            S_DONE:   w_next = S_IDLE;
            S_ABORT:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Column latch, pair indices and the per-job watchdog counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_colmat <= '0;
            r_i      <= 8'd0;
            r_j      <= 8'd0;
            r_timer  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_colmat <= bus.colmat;
                        r_i      <= 8'd0;
                        r_j      <= 8'd0;
                    end
                end
                S_ISSUE: r_timer <= 32'd0;
                S_WAIT:  if (!bus.ip_endflag) r_timer <= r_timer + 32'd1;
                S_NEXT: begin
                    if (!w_last_j) begin
                        r_j <= r_j + 8'd1;
                    end else if (!w_last_i) begin
                        r_i <= r_i + 8'd1;
                        r_j <= r_i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ip_start <= 1'b0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_wr_row   <= 8'd0;
            r_wr_col   <= 8'd0;
            r_wr_data  <= '0;
        end else begin
            r_ip_start <= (w_next == S_ISSUE);
            r_wr_en    <= (w_next == S_WRITE) || (w_next == S_MIRROR);
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
            if (r_state == S_IDLE && bus.go) r_error <= 1'b0;
            else if (w_next == S_ABORT)      r_error <= 1'b1;
            if (w_next == S_WRITE) begin
                r_wr_row  <= r_i;
                r_wr_col  <= r_j;
                r_wr_data <= bus.ip_result;
            end else if (w_next == S_MIRROR) begin
                r_wr_row  <= r_j;
                r_wr_col  <= r_i;
            end
        end
    end

    assign bus.ip_vector1    = w_vec1;
    assign bus.ip_vector2    = w_vec2;
    assign bus.ip_maximumPos = 32'(N - 1);
    assign bus.ip_resetValue = 32'd0;
    assign bus.ip_addSubs    = 1'b1;
    assign bus.ip_start      = r_ip_start;
    assign bus.wr_en         = r_wr_en;
    assign bus.wr_row        = r_wr_row;
    assign bus.wr_col        = r_wr_col;
    assign bus.wr_data       = r_wr_data;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.error         = r_error;
endmodule

// File: doc/gram_scheduler.md
Name: gram_scheduler

Overview:
- Sequences one shared InnerProduct datapath to build the symmetric Gram matrix G = A^T·A of an M-column, N-row Q17.15 matrix, the first stage of the pseudoinverse pipeline.
- Latches the column set on `go` and issues one inner-product job per upper-triangle pair (i,j), i≤j.
- Writes each result to G[i][j] and mirrors it to G[j][i] through a single write port.
- A per-job watchdog aborts the sequence if the datapath never completes.

Parameters:
- M, 3: number of columns (Gram matrix is M×M); range 1..255.
- N, 3: vector length per column; range 1..2^32.
- nBits, 32: element width, Q17.15 signed.
- TIMEOUT, 255: maximum cycles to wait for ip_endflag per job, counted from the ip_start cycle.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle start request; ignored while busy=1.
- colmat  in  nBits*N*M  columns. Column 0 is in the MSBs: column k = bits [nBits*N*(M-k)-1 -: nBits*N]. Element packing within a column matches the InnerProduct vector (element 0 in MSBs).
- ip_vector1  out  nBits*N  column i of the latched matrix.
- ip_vector2  out  nBits*N  column j of the latched matrix.
- ip_maximumPos  out  32  constant N-1.
- ip_resetValue  out  32  constant 0.
- ip_addSubs  out  1  constant 1 (accumulate).
- ip_start  out  1  one-cycle job start.
- ip_endflag  in  1  datapath completion level.
- ip_result  in  nBits  signed datapath result.
- wr_en  out  1  Gram write strobe.
- wr_row  out  8  write row index.
- wr_col  out  8  write column index.
- wr_data  out  nBits  write data; ip_result passed through unchanged.
- busy  out  1  high from the cycle after an accepted go until the DONE/ABORT cycle, inclusive.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky timeout flag; cleared by the next accepted go or by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; i, j, timer are cleared.
  - ip_start, wr_en, busy, done and error are 0.
  - wr_row, wr_col and wr_data are 0; the latched column register is 0.
- Constant outputs: ip_maximumPos, ip_resetValue and ip_addSubs are combinational constants, valid during reset.
- FSM states: IDLE, ISSUE, ARM, WAIT, WRITE, MIRROR, NEXT, DONE, ABORT.
- IDLE:
  - When go=1: latch colmat, set i=0, j=0, clear error, go to ISSUE.
  - Latency: ip_start is high on the cycle after go is sampled.
- ISSUE:
  - ip_start=1 for exactly one cycle; timer=0; go to ARM.
  - ip_vector1 and ip_vector2 are stable from ISSUE through WRITE.
- ARM: one cycle in which ip_endflag is ignored, so a stale flag from the previous job is not taken. Go to WAIT.
- WAIT:
  - If ip_endflag=1, capture ip_result and go to WRITE.
  - Otherwise timer++. When timer reaches TIMEOUT, go to ABORT.
- WRITE: wr_en=1, wr_row=i, wr_col=j, wr_data=captured result. Go to MIRROR if i≠j, else NEXT.
- MIRROR: wr_en=1, wr_row=j, wr_col=i, same data. Go to NEXT.
- NEXT:
  - If j<M-1: j++.
  - Else if i<M-1: i++, j=i+1-1, i.e. j is set to the new i.
  - Go to ISSUE. If i=j=M-1, go to DONE instead.
- DONE: done=1 for one cycle, busy drops to 0 in the following cycle, return to IDLE.
- ABORT: error=1 (sticky), no write, return to IDLE. done stays 0.
- Job order is row-major over the upper triangle: (0,0),(0,1),…,(0,M-1),(1,1),…,(M-1,M-1).
- Totals per run: M(M+1)/2 ip_start pulses and M² wr_en pulses.
- Boundary conditions:
  - go during busy: ignored, no relatch.
  - go in the DONE cycle: ignored.
  - M=1: one job, one write (0,0), then DONE.
  - ip_endflag already high in ARM: ignored. If it is still high in WAIT, it is accepted, because ARM guarantees at least 2 cycles after ip_start.
  - reset mid-run: immediate return to IDLE. ip_start and wr_en drop asynchronously; no done pulse.
  - colmat changes during a run: no effect, because the latched copy is used.
- Arithmetic: no width changes. ip_result is treated as opaque signed Q17.15 and forwarded as-is.

Test Plan:
- Reset/constants: hold reset=0 → all outputs 0; ip_maximumPos=2, ip_resetValue=0, ip_addSubs=1.
- Full run (M=N=3): columns (1,2,3),(4,5,6),(7,8,9) in Q17.15, real InnerProduct attached, go pulse.
  - Expect 6 ip_start pulses and 9 writes, in order: (0,0)=14, (0,1)=32, (1,0)=32, (0,2)=50, (2,0)=50, (1,1)=77, (1,2)=122, (2,1)=122, (2,2)=194. Each value ×2^15.
  - Expect one done pulse and error=0.
- Latency: go sampled at cycle t → ip_start=1 at t+1; busy=1 at t+1.
- Ignored go: pulse go mid-run and change colmat → write sequence and values identical to the full run; no extra ip_start.
- Timeout: stub holds ip_endflag=0 (TIMEOUT=255 at default; set TIMEOUT=10 in the bench) → ABORT on the 10th WAIT-cycle increment with no write; error=1, done=0. A new go clears error.
- Reset mid-run: assert reset=0 during WAIT of job (0,2) → ip_start and wr_en drop to 0 immediately. After release: IDLE, busy=0, no done; a new go restarts at (0,0).
